// File: rtl/eif_spike_monitor_if.sv
// Bus between a spike source and eif_spike_monitor: neuron inputs, window
// control, readout select and the held-result readout.
interface eif_spike_monitor_if #(
    parameter int WIN_W = 16
);
    logic             spike_in;
    logic [7:0]       state_in;
    logic             start;
    logic [WIN_W-1:0] window_len;
    logic [1:0]       sel;
    logic [7:0]       data_out;
    logic             busy;
    logic             result_valid;

    // Stimulus / controller side
    modport master (
        output spike_in,
        output state_in,
        output start,
        output window_len,
        output sel,
        input  data_out,
        input  busy,
        input  result_valid
    );

    // Monitor side
    modport slave (
        input  spike_in,
        input  state_in,
        input  start,
        input  window_len,
        input  sel,
        output data_out,
        output busy,
        output result_valid
    );
endinterface

// File: rtl/eif_spike_monitor.sv
// Spike statistics over a programmable window: spike count, minimum
// inter-spike interval, burst count and peak membrane state. Results are
// held until the next report and read out 8 bits at a time through sel.
module eif_spike_monitor #(
    parameter int WIN_W     = 16,
    parameter int BURST_ISI = 4,
    parameter int BURST_MIN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    eif_spike_monitor_if.slave   mon
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [WIN_W-1:0] WIN_ONE     = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [8:0]       BURST_ISI_L = 9'(BURST_ISI);
    localparam logic [7:0]       BURST_MIN_L = 8'(BURST_MIN);

    state_t           state_q, state_d;
    logic             spike_q;
    logic [WIN_W-1:0] win_q,   win_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic [7:0]       isi_q,   isi_d;
    logic [7:0]       min_q,   min_d;
    logic [7:0]       run_q,   run_d;
    logic [7:0]       burst_q, burst_d;
    logic [7:0]       peak_q,  peak_d;
    logic             seen_q,  seen_d;

    logic [7:0]       h_cnt_q,   h_cnt_d;
    logic [7:0]       h_min_q,   h_min_d;
    logic [7:0]       h_burst_q, h_burst_d;
    logic [7:0]       h_peak_q,  h_peak_d;

    logic             event_w;
    logic [8:0]       isi_len_w;
    logic             linked_w;
    logic [7:0]       run_nxt;

    // Rising edge of the spike level; a level already high never re-triggers
    assign event_w   = mon.spike_in & ~spike_q;
    // Interval of the current event: cycles since the previous event edge
    assign isi_len_w = {1'b0, isi_q} + 9'd1;
    assign linked_w  = seen_q && (isi_len_w <= BURST_ISI_L);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN counts win_q down to 1, REPORT is a single cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mon.start) begin
                    state_d = (mon.window_len == '0) ? S_REPORT : S_RUN;
                end
            end
            S_RUN: begin
                if (win_q == WIN_ONE) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        mon.busy         = (state_q == S_RUN) || (state_q == S_REPORT);
        mon.result_valid = (state_q == S_REPORT);
    end

    // Working and held register next values
    always_comb begin
        win_d     = win_q;
        cnt_d     = cnt_q;
        isi_d     = isi_q;
        min_d     = min_q;
        run_d     = run_q;
        burst_d   = burst_q;
        peak_d    = peak_q;
        seen_d    = seen_q;
        run_nxt   = run_q;
        h_cnt_d   = h_cnt_q;
        h_min_d   = h_min_q;
        h_burst_d = h_burst_q;
        h_peak_d  = h_peak_q;

        case (state_q)
            S_IDLE: begin
                if (mon.start) begin
                    win_d   = mon.window_len;
                    cnt_d   = 8'd0;
                    isi_d   = 8'd0;
                    min_d   = 8'hFF;
                    run_d   = 8'd0;
                    burst_d = 8'd0;
                    peak_d  = 8'd0;
                    seen_d  = 1'b0;
                end
            end
            S_RUN: begin
                win_d = win_q - WIN_ONE;
                if (mon.state_in > peak_q) begin
                    peak_d = mon.state_in;
                end
                if (event_w) begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    isi_d  = 8'd0;
                    seen_d = 1'b1;
                    // A saturated interval (256) can never beat min, which is <= 255
                    if (seen_q && (isi_len_w < {1'b0, min_q})) begin
                        min_d = isi_len_w[7:0];
                    end
                    if (linked_w) begin
                        run_nxt = (run_q >= BURST_MIN_L) ? BURST_MIN_L : run_q + 8'd1;
                    end else begin
                        run_nxt = 8'd1;
                    end
                    run_d = run_nxt;
                    // Count a burst only on the event that first reaches BURST_MIN
                    if ((run_nxt == BURST_MIN_L) && (run_q != BURST_MIN_L) && (burst_q != 8'hFF)) begin
                        burst_d = burst_q + 8'd1;
                    end
                end else if (isi_q != 8'hFF) begin
                    isi_d = isi_q + 8'd1;
                end
            end
            default: ;
        endcase

        // Publish on the edge entering REPORT so the last RUN cycle is included
        if ((state_d == S_REPORT) && (state_q != S_REPORT)) begin
            h_cnt_d   = cnt_d;
            h_min_d   = min_d;
            h_burst_d = burst_d;
            h_peak_d  = peak_d;
        end
    end

    // Working, held and spike-history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q   <= 1'b0;
            win_q     <= '0;
            cnt_q     <= 8'd0;
            isi_q     <= 8'd0;
            min_q     <= 8'd0;
            run_q     <= 8'd0;
            burst_q   <= 8'd0;
            peak_q    <= 8'd0;
            seen_q    <= 1'b0;
            h_cnt_q   <= 8'd0;
            h_min_q   <= 8'd0;
            h_burst_q <= 8'd0;
            h_peak_q  <= 8'd0;
        end else begin
            spike_q   <= mon.spike_in;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            isi_q     <= isi_d;
            min_q     <= min_d;
            run_q     <= run_d;
            burst_q   <= burst_d;
            peak_q    <= peak_d;
            seen_q    <= seen_d;
            h_cnt_q   <= h_cnt_d;
            h_min_q   <= h_min_d;
            h_burst_q <= h_burst_d;
            h_peak_q  <= h_peak_d;
        end
    end

    // Readout mux of the held results
    always_comb begin
        case (mon.sel)
            2'd0:    mon.data_out = h_cnt_q;
            2'd1:    mon.data_out = h_min_q;
            2'd2:    mon.data_out = h_burst_q;
            default: mon.data_out = h_peak_q;
        endcase
    end

endmodule

// File: tb/tb_eif_spike_monitor.sv
// Directed bench for eif_spike_monitor: one task per scenario, inline checks.
module tb_eif_spike_monitor;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    eif_spike_monitor_if #(.WIN_W(16)) bus ();

    eif_spike_monitor #(
        .WIN_W(16),
        .BURST_ISI(4),
        .BURST_MIN(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reads all four held results (within the current cycle) and checks them
    task automatic read_results(input string tag, input logic [7:0] e_cnt, input logic [7:0] e_min,
                                input logic [7:0] e_burst, input logic [7:0] e_peak);
        logic [7:0] got [4];
        logic [7:0] exp [4];
        exp[0] = e_cnt; exp[1] = e_min; exp[2] = e_burst; exp[3] = e_peak;
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            #1;
            got[s] = bus.data_out;
            checks++;
            if (got[s] !== exp[s]) begin
                failures++;
                $display("FAIL %s_sel%0d got=0x%02h want=0x%02h", tag, s, got[s], exp[s]);
            end
        end
        $display("window %s: cnt=%0d min_isi=%0d burst=%0d peak=%0d", tag, got[0], got[1], got[2], got[3]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.spike_in = 1'b0; bus.state_in = 8'd0; bus.start = 1'b0;
        bus.window_len = 16'd0; bus.sel = 2'd0;
        tick; tick;
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b rv=%b want 0 0", bus.busy, bus.result_valid);
        end
        read_results("reset", 8'd0, 8'd0, 8'd0, 8'd0);
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int rv_seen = 0;
        bus.state_in = 8'h10; bus.window_len = 16'd20; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_run got=%b want=1", bus.busy);
        end
        for (int c = 1; c <= 20; c++) begin
            bus.spike_in = (c == 2) || (c == 5) || (c == 9);
            if (bus.result_valid) rv_seen++;
            tick;
        end
        bus.spike_in = 1'b0;
        checks++;
        if (rv_seen != 0 || bus.result_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_rv_timing got early=%0d rv21=%b want 0 1", rv_seen, bus.result_valid);
        end
        read_results("basic", 8'd3, 8'd3, 8'd1, 8'h10);
        tick;
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle22 got busy=%b rv=%b want 0 0", bus.busy, bus.result_valid);
        end
    endtask

    task automatic test_single_and_level;
        bus.state_in = 8'd0; bus.window_len = 16'd10; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            bus.spike_in = (c == 3);
            tick;
        end
        bus.spike_in = 1'b0;
        read_results("single", 8'd1, 8'hFF, 8'd0, 8'd0);
        tick;
        // Level high before start and throughout the window: no edge
        bus.spike_in = 1'b1;
        tick;
        bus.window_len = 16'd10; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c <= 10; c++) tick;
        checks++;
        if (bus.result_valid !== 1'b1) begin
            failures++;
            $display("FAIL level_rv got=%b want=1", bus.result_valid);
        end
        read_results("level", 8'd0, 8'hFF, 8'd0, 8'd0);
        bus.spike_in = 1'b0;
        tick; tick;
    endtask

    task automatic test_long_level_peak;
        bus.window_len = 16'd30; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            bus.spike_in = (c >= 3) && (c <= 12);
            bus.state_in = (c == 7) ? 8'hC8 : 8'(c - 1);
            tick;
        end
        bus.spike_in = 1'b0; bus.state_in = 8'd0;
        read_results("peak", 8'd1, 8'hFF, 8'd0, 8'hC8);
        tick;
    endtask

    task automatic test_saturate;
        bus.window_len = 16'd700; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c <= 700; c++) begin
            bus.spike_in = (c % 2 == 0);
            tick;
        end
        bus.spike_in = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b1) begin
            failures++;
            $display("FAIL sat_rv got=%b want=1", bus.result_valid);
        end
        read_results("saturate", 8'd255, 8'd2, 8'd1, 8'd0);
        tick;
    endtask

    task automatic test_reset_abort;
        int rv_seen = 0;
        bus.window_len = 16'd50; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            bus.spike_in = (c % 3 == 0);
            if (c == 20) rst = 1'b1;
            tick;
        end
        rst = 1'b0;
        bus.spike_in = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_flags got busy=%b rv=%b want 0 0", bus.busy, bus.result_valid);
        end
        read_results("abort", 8'd0, 8'd0, 8'd0, 8'd0);
        for (int c = 0; c < 40; c++) begin
            if (bus.result_valid || bus.busy) rv_seen++;
            tick;
        end
        checks++;
        if (rv_seen != 0) begin
            failures++;
            $display("FAIL abort_quiet got active_cycles=%0d want=0", rv_seen);
        end
        // Fresh window after the abort
        bus.window_len = 16'd5; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            bus.spike_in = (c == 1) || (c == 3);
            tick;
        end
        bus.spike_in = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b1) begin
            failures++;
            $display("FAIL restart_rv got=%b want=1", bus.result_valid);
        end
        read_results("restart", 8'd2, 8'd2, 8'd0, 8'd0);
        tick;
    endtask

    task automatic test_zero_len_and_extra_starts;
        int rv_cnt = 0;
        int rv_cycle = -1;
        bus.state_in = 8'h55; bus.window_len = 16'd0; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_rv1 got rv=%b busy=%b want 1 1", bus.result_valid, bus.busy);
        end
        read_results("zero", 8'd0, 8'hFF, 8'd0, 8'd0);
        tick;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_idle2 got busy=%b want=0", bus.busy);
        end
        bus.state_in = 8'd0;
        // start held high through RUN and REPORT; window_len changes mid-run
        bus.window_len = 16'd4; bus.start = 1'b1;
        tick;
        bus.window_len = 16'd9;
        for (int c = 1; c <= 12; c++) begin
            if (c >= 6) bus.start = 1'b0;
            if (bus.result_valid) begin
                rv_cnt++;
                rv_cycle = c;
            end
            if (c == 6) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL extra_busy6 got=%b want=0", bus.busy);
                end
            end
            tick;
        end
        checks++;
        if (rv_cnt != 1 || rv_cycle != 5) begin
            failures++;
            $display("FAIL extra_starts got pulses=%0d at=%0d want 1 at 5", rv_cnt, rv_cycle);
        end
        $display("window extra_starts: pulses=%0d at_cycle=%0d", rv_cnt, rv_cycle);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_single_and_level;
        test_long_level_peak;
        test_saturate;
        test_reset_abort;
        test_zero_len_and_extra_starts;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eif_spike_monitor.md
Name: eif_spike_monitor

Overview:
Downstream analysis stage for eif_neuron. It consumes the neuron's spike line and 8-bit membrane state. Over a programmable observation window it measures spike count, minimum inter-spike interval (ISI), burst count and peak membrane state. Results are held in registers and read out 8 bits at a time through a select mux, so the block fits the 8-bit output pins of the tt_um top level.

Parameters:
WIN_W, 16, width of window_len and the window countdown counter
BURST_ISI, 4, an ISI <= this value (cycles) links two events into one burst run
BURST_MIN, 3, number of linked events that counts as one burst (>=2)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
spike_in  input  1  neuron spike line (level; may stay high several cycles)
state_in  input  8  neuron membrane state, unsigned
start  input  1  request a measurement window; sampled only in IDLE
window_len  input  WIN_W  window length in cycles; latched on accepted start
sel  input  2  readout select: 0 spike_cnt, 1 min_isi, 2 burst_cnt, 3 peak_state
data_out  output  8  selected held result (combinational mux of registers)
busy  output  1  high in RUN and REPORT
result_valid  output  1  one-cycle pulse; held results updated in this cycle

Behaviour:
- Reset (rst=1 at clk edge): FSM to IDLE; clear all counters and held results; result_valid=0, busy=0, data_out=0 for every sel. Reset mid-window aborts the window with no report.
- Event detection: event = spike_in & ~spike_q. spike_q is registered every cycle in all states. A level already high when RUN begins is not an event.
- FSM:
  - IDLE -> RUN on start=1 with window_len!=0. Latch window_len and clear working registers: cnt=0, min=0xFF, burst=0, peak=0, run=0, seen=0.
  - IDLE -> REPORT on start=1 with window_len==0. Working registers are cleared first, so REPORT publishes cnt=0, min=0xFF, burst=0, peak=0.
  - RUN lasts exactly window_len cycles, counted down to 1. An event in the last RUN cycle is counted. RUN -> REPORT.
  - REPORT lasts one cycle, then IDLE. start is ignored in RUN and REPORT.
- Working registers, updated in RUN cycles only:
  - cnt: +1 per event, saturates at 255.
  - isi_ctr: resets to 0 on an event, otherwise +1, saturating at 255. The ISI of an event is isi_ctr+1 (edges at cycles t and t+3 give ISI 3). It is valid only when seen=1, i.e. after the first event in this window.
  - min: min(min, ISI) on each event with seen=1. It stays 0xFF if there are fewer than 2 events.
  - run: on an event, if seen=1 and ISI<=BURST_ISI then run+1 (saturating at BURST_MIN), else run=1. burst is incremented once, when run reaches BURST_MIN; further linked events do not increment it again. burst saturates at 255.
  - peak: max(peak, state_in) each RUN cycle.
- Held results are loaded from the working registers at the edge entering REPORT (the RUN->REPORT or IDLE->REPORT transition). result_valid=1 for that one REPORT cycle. Held values persist until the next report or reset.
- data_out is combinational on sel and the held registers, with no added latency.
- Latency: start accepted in cycle 0; RUN occupies cycles 1..N; result_valid=1 in cycle N+1; busy=0 from cycle N+2.

Test Plan:
1. window_len=20, 1-cycle spikes at RUN cycles 2, 5, 9 (ISI 3, 4) -> result_valid in cycle 21; cnt=3, min_isi=3, burst_cnt=1, busy low in cycle 22.
2. window_len=10, one spike -> cnt=1, min_isi=0xFF, burst_cnt=0. Also spike_in high from before start through the whole window -> cnt=0.
3. spike_in held high 10 cycles, then low, inside window_len=30 -> cnt=1; state_in ramp 0..29 with a 0xC8 glitch at cycle 7 -> peak_state=0xC8 (200).
4. Pulses every 2 cycles for window_len=700 -> cnt=255 (saturated), min_isi=2, burst_cnt=1.
5. window_len=50, rst asserted at RUN cycle 20 -> next cycle busy=0, no result_valid, data_out=0 for sel=0..3. A new start then works normally.
6. window_len=0 -> result_valid in cycle 1, values 0/0xFF/0/0. Extra start pulses during RUN and REPORT are ignored: exactly one result_valid per accepted start.
